// File: rtl/regbank_pkg.sv
// regbank_pkg: shared constants and types for the LEGv8 register bank.
package regbank_pkg;
    localparam int NREGS = 32;
    localparam logic [4:0] XZR = 5'd31;
    typedef logic [4:0] reg_addr_t;
endpackage

// File: rtl/regbank_sb_mux.sv
// regbank_sb_mux: 32:1 read-select mux used for each register read port.
module regbank_sb_mux
    import regbank_pkg::*;
#(
    parameter int size = 64
) (
    input  logic [NREGS-1:0][size-1:0] d_i,
    input  reg_addr_t                  sel_i,
    output logic [size-1:0]            y_o
);
    assign y_o = d_i[sel_i];
endmodule

// File: rtl/regbank_sb.sv
// regbank_sb: 31x64 register bank with XZR, write-to-read bypass and a
// busy-bit scoreboard that flags RAW/WAW hazards at issue.
module regbank_sb
    import regbank_pkg::*;
#(
    parameter int SIZE = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  reg_addr_t        wa,
    input  logic [SIZE-1:0]  wd,
    input  reg_addr_t        ra1,
    input  reg_addr_t        ra2,
    output logic [SIZE-1:0]  rd1,
    output logic [SIZE-1:0]  rd2,
    input  logic             issue_valid,
    input  reg_addr_t        issue_rd,
    input  logic             issue_wr,
    output logic             hazard,
    output logic [NREGS-1:0] busy
);
    logic [NREGS-2:0][SIZE-1:0] regs_q;
    logic [NREGS-2:0]           busy_q;
    logic [NREGS-1:0]           busy_d;
    logic [NREGS-1:0][SIZE-1:0] mux_in;
    logic [SIZE-1:0]            m1, m2;
    logic                       issue_set;

    assign mux_in = {{SIZE{1'b0}}, regs_q};
    assign busy   = {1'b0, busy_q};

    // A writeback landing this cycle resolves the dependency via the bypass.
    function automatic logic pending(input reg_addr_t a);
        return busy[a] && !(we && wa == a);
    endfunction

    assign hazard    = !reset && issue_valid &&
                       (pending(ra1) || pending(ra2) || (issue_wr && pending(issue_rd)));
    assign issue_set = issue_valid && !hazard && issue_wr && issue_rd != XZR;

    regbank_sb_mux #(.size(SIZE)) u_mux1 (.d_i(mux_in), .sel_i(ra1), .y_o(m1));
    regbank_sb_mux #(.size(SIZE)) u_mux2 (.d_i(mux_in), .sel_i(ra2), .y_o(m2));

    assign rd1 = (reset || ra1 == XZR) ? '0 : (we && wa == ra1) ? wd : m1;
    assign rd2 = (reset || ra2 == XZR) ? '0 : (we && wa == ra2) ? wd : m2;

    // Set after clear so a new producer wins over a retiring one.
    always_comb begin
        busy_d = busy;
        if (we) busy_d[wa] = 1'b0;
        if (issue_set) busy_d[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            if (we && wa != XZR) regs_q[wa] <= wd;
            busy_q <= busy_d[NREGS-2:0];
        end
    end
endmodule

// File: tb/tb_regbank_sb.sv
// tb_regbank_sb: directed plus randomized checks of regbank_sb against an
// array-based reference model of the register bank and scoreboard.
module tb_regbank_sb;
    logic        clk = 1'b0;
    logic        reset, we, issue_valid, issue_wr;
    logic [4:0]  wa, ra1, ra2, issue_rd;
    logic [63:0] wd, rd1, rd2;
    logic        hazard;
    logic [31:0] busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] mregs [32];
    bit          mbusy [32];

    always #5 clk = ~clk;

    regbank_sb #(.SIZE(64)) dut (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wr(issue_wr),
        .hazard(hazard), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] exp_rd(input logic [4:0] a);
        if (reset || a == 5'd31) return 64'd0;
        if (we && wa == a) return wd;
        return mregs[a];
    endfunction

    function automatic bit pend(input logic [4:0] a);
        return mbusy[a] && !(we && wa == a);
    endfunction

    function automatic bit exp_haz();
        return !reset && issue_valid && (pend(ra1) || pend(ra2) || (issue_wr && pend(issue_rd)));
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = mbusy[i];
        return v;
    endfunction

    task automatic drive(input logic r, input logic w, input logic [4:0] a, input logic [63:0] d,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic iv, input logic [4:0] ird, input logic iw);
        reset = r; we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
        issue_valid = iv; issue_rd = ird; issue_wr = iw;
        #1;
    endtask

    task automatic step();
        bit h;
        check("rd1", rd1, exp_rd(ra1));
        check("rd2", rd2, exp_rd(ra2));
        check("hazard", 64'(hazard), 64'(exp_haz()));
        check("busy", 64'(busy), 64'(exp_busy()));
        h = exp_haz();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mregs[i] = 64'd0;
                mbusy[i] = 1'b0;
            end
        end else begin
            if (we && wa != 5'd31) mregs[wa] = wd;
            if (we) mbusy[wa] = 1'b0;
            if (issue_valid && !h && issue_wr && issue_rd != 5'd31) mbusy[issue_rd] = 1'b1;
        end
        #1;
    endtask

    function automatic logic [4:0] raddr();
        return ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 9));
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) begin
            mregs[i] = 64'd0;
            mbusy[i] = 1'b0;
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 5, 31, 0, 0, 0);
        check("rst_rd1", rd1, 64'd0);
        check("rst_rd2", rd2, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_haz", 64'(hazard), 64'd0);
        step();
        drive(0, 1, 3, 64'hDEADBEEF_CAFEF00D, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 3, 0, 0, 0, 0);
        check("wr_rd1", rd1, 64'hDEADBEEF_CAFEF00D);
        step();
        drive(0, 1, 31, 64'd1, 31, 31, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 31, 0, 0, 0, 0);
        check("xzr_rd1", rd1, 64'd0);
        step();
        drive(0, 1, 7, 64'd10, 0, 0, 0, 0, 0);
        step();
        drive(0, 1, 7, 64'd20, 7, 7, 0, 0, 0);
        check("byp_rd1", rd1, 64'd20);
        check("byp_rd2", rd2, 64'd20);
        step();
        drive(0, 0, 0, 0, 7, 7, 0, 0, 0);
        check("byp_after", rd1, 64'd20);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 9, 1);
        step();
        drive(0, 0, 0, 0, 9, 0, 1, 0, 0);
        check("raw_busy9", 64'(busy[9]), 64'd1);
        check("raw_haz", 64'(hazard), 64'd1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("raw_busy_kept", 64'(busy), 64'h200);
        step();
        drive(0, 1, 9, 64'd55, 9, 0, 1, 0, 0);
        check("raw_wb_haz", 64'(hazard), 64'd0);
        check("raw_wb_rd1", rd1, 64'd55);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 4, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 4, 1);
        check("waw_haz", 64'(hazard), 64'd1);
        step();
        drive(0, 1, 4, 64'd7, 0, 0, 1, 4, 1);
        check("waw_wb_haz", 64'(hazard), 64'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 31, 1);
        check("setwins_busy4", 64'(busy[4]), 64'd1);
        check("xzr_issue_haz", 64'(hazard), 64'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 9, 1);
        check("xzr_issue_busy", 64'(busy), 64'h10);
        step();
        drive(1, 1, 3, 64'h1234, 3, 7, 1, 5, 1);
        check("mid_busy_pre", 64'(busy), 64'h210);
        check("mid_haz_rst", 64'(hazard), 64'd0);
        step();
        drive(0, 0, 0, 0, 3, 7, 0, 0, 0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_rd3", rd1, 64'd0);
        check("mid_rd7", rd2, 64'd0);
        step();
        for (int n = 0; n < 500; n++) begin
            drive(($urandom_range(0, 59) == 0), 1'($urandom), raddr(), {$urandom, $urandom},
                  raddr(), raddr(), 1'($urandom), raddr(), 1'($urandom));
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
